// File: rtl/udp_reg_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | udp_reg_arbiter                                                          |
// | Round-robin arbiter sharing the register master core_reg_* port between  |
// | port A (CPCI host) and port B (config loader). Optional requester lock   |
// | is enabled by defining UDP_REG_ARB_LOCK_EN.                              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module udp_reg_arbiter #(
    parameter int LOCK_LIMIT = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            a_req,
    output logic                            a_ack,
    input  logic                            a_rd_wr_L,
    input  logic [`UDP_REG_ADDR_WIDTH-1:0]  a_addr,
    input  logic [`CPCI_NF2_DATA_WIDTH-1:0] a_wr_data,
    output logic [`CPCI_NF2_DATA_WIDTH-1:0] a_rd_data,
    input  logic                            b_req,
    output logic                            b_ack,
    input  logic                            b_rd_wr_L,
    input  logic [`UDP_REG_ADDR_WIDTH-1:0]  b_addr,
    input  logic [`CPCI_NF2_DATA_WIDTH-1:0] b_wr_data,
    output logic [`CPCI_NF2_DATA_WIDTH-1:0] b_rd_data,
`ifdef UDP_REG_ARB_LOCK_EN
    input  logic                            a_lock,
    input  logic                            b_lock,
`endif
    output logic                            core_reg_req,
    input  logic                            core_reg_ack,
    output logic                            core_reg_rd_wr_L,
    output logic [`UDP_REG_ADDR_WIDTH-1:0]  core_reg_addr,
    output logic [`CPCI_NF2_DATA_WIDTH-1:0] core_reg_wr_data,
    input  logic [`CPCI_NF2_DATA_WIDTH-1:0] core_reg_rd_data
);

    localparam int AW = `UDP_REG_ADDR_WIDTH;
    localparam int DW = `CPCI_NF2_DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            grant_q, grant_d;
    logic            last_q, last_d;
    logic            req_q, req_d;
    logic            rd_wr_q, rd_wr_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;
    logic            a_ack_q, a_ack_d;
    logic            b_ack_q, b_ack_d;
    logic [DW-1:0]   a_rd_data_q, a_rd_data_d;
    logic [DW-1:0]   b_rd_data_q, b_rd_data_d;

    logic            sel_idle;
    logic            src;
    logic            gnt_req;
    logic            src_rd_wr;
    logic [AW-1:0]   src_addr;
    logic [DW-1:0]   src_wr_data;

    // On a tie the port that was not served last wins.
    assign sel_idle    = (a_req && b_req) ? ~last_q : b_req;
    assign src         = (state_q == IDLE) ? sel_idle : grant_q;
    assign src_rd_wr   = src ? b_rd_wr_L : a_rd_wr_L;
    assign src_addr    = src ? b_addr    : a_addr;
    assign src_wr_data = src ? b_wr_data : a_wr_data;
    assign gnt_req     = grant_q ? b_req : a_req;

`ifdef UDP_REG_ARB_LOCK_EN
    localparam int            CW       = (LOCK_LIMIT > 1) ? $clog2(LOCK_LIMIT) : 1;
    localparam logic [CW-1:0] LOCK_MAX = CW'(LOCK_LIMIT - 1);

    logic [CW-1:0] lock_cnt_q, lock_cnt_d;
    logic          held_q, held_d;
    logic          gnt_lock;

    assign gnt_lock = grant_q ? b_lock : a_lock;
`endif

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        req_d       = req_q;
        rd_wr_d     = rd_wr_q;
        addr_d      = addr_q;
        wr_data_d   = wr_data_q;
        a_ack_d     = 1'b0;
        b_ack_d     = 1'b0;
        a_rd_data_d = a_rd_data_q;
        b_rd_data_d = b_rd_data_q;
`ifdef UDP_REG_ARB_LOCK_EN
        lock_cnt_d  = lock_cnt_q;
        held_d      = held_q;
`endif
        case (state_q)
            IDLE: begin
                if (a_req || b_req) begin
                    grant_d   = sel_idle;
                    req_d     = 1'b1;
                    rd_wr_d   = src_rd_wr;
                    addr_d    = src_addr;
                    wr_data_d = src_wr_data;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                // A completion in the same cycle as a dropped request still counts.
                if (core_reg_ack) begin
                    req_d   = 1'b0;
                    state_d = DONE;
                    if (grant_q) begin
                        b_ack_d     = 1'b1;
                        b_rd_data_d = core_reg_rd_data;
                    end else begin
                        a_ack_d     = 1'b1;
                        a_rd_data_d = core_reg_rd_data;
                    end
                end else if (!gnt_req) begin
                    req_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
`ifdef UDP_REG_ARB_LOCK_EN
                // held_q: the locked owner has dropped req and its next rising req reissues directly.
                if (held_q) begin
                    if (!gnt_lock) begin
                        last_d     = grant_q;
                        lock_cnt_d = '0;
                        held_d     = 1'b0;
                        state_d    = IDLE;
                    end else if (gnt_req) begin
                        req_d      = 1'b1;
                        rd_wr_d    = src_rd_wr;
                        addr_d     = src_addr;
                        wr_data_d  = src_wr_data;
                        lock_cnt_d = lock_cnt_q + 1'b1;
                        held_d     = 1'b0;
                        state_d    = ISSUE;
                    end
                end else if (!gnt_req) begin
                    if (gnt_lock && (lock_cnt_q < LOCK_MAX)) begin
                        held_d = 1'b1;
                    end else begin
                        last_d     = grant_q;
                        lock_cnt_d = '0;
                        state_d    = IDLE;
                    end
                end
`else
                if (!gnt_req) begin
                    last_d  = grant_q;
                    state_d = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= 1'b0;
            last_q      <= 1'b1;
            req_q       <= 1'b0;
            rd_wr_q     <= 1'b0;
            addr_q      <= '0;
            wr_data_q   <= '0;
            a_ack_q     <= 1'b0;
            b_ack_q     <= 1'b0;
            a_rd_data_q <= '0;
            b_rd_data_q <= '0;
`ifdef UDP_REG_ARB_LOCK_EN
            lock_cnt_q  <= '0;
            held_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            req_q       <= req_d;
            rd_wr_q     <= rd_wr_d;
            addr_q      <= addr_d;
            wr_data_q   <= wr_data_d;
            a_ack_q     <= a_ack_d;
            b_ack_q     <= b_ack_d;
            a_rd_data_q <= a_rd_data_d;
            b_rd_data_q <= b_rd_data_d;
`ifdef UDP_REG_ARB_LOCK_EN
            lock_cnt_q  <= lock_cnt_d;
            held_q      <= held_d;
`endif
        end
    end

    assign core_reg_req     = req_q;
    assign core_reg_rd_wr_L = rd_wr_q;
    assign core_reg_addr    = addr_q;
    assign core_reg_wr_data = wr_data_q;
    assign a_ack            = a_ack_q;
    assign b_ack            = b_ack_q;
    assign a_rd_data        = a_rd_data_q;
    assign b_rd_data        = b_rd_data_q;

endmodule

`default_nettype wire

// File: tb/tb_udp_reg_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_udp_reg_arbiter                                                       |
// | Self-checking bench: register-master model, scoreboard and scenarios.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module tb_udp_reg_arbiter;

    localparam int AW = `UDP_REG_ADDR_WIDTH;
    localparam int DW = `CPCI_NF2_DATA_WIDTH;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_req, a_ack, a_rd_wr_L, b_req, b_ack, b_rd_wr_L;
    logic [AW-1:0] a_addr, b_addr, core_reg_addr;
    logic [DW-1:0] a_wr_data, a_rd_data, b_wr_data, b_rd_data;
    logic          core_reg_req, core_reg_ack, core_reg_rd_wr_L;
    logic [DW-1:0] core_reg_wr_data, core_reg_rd_data;
`ifdef UDP_REG_ARB_LOCK_EN
    logic          a_lock, b_lock;
`endif

    udp_reg_arbiter #(.LOCK_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_ack(a_ack), .a_rd_wr_L(a_rd_wr_L), .a_addr(a_addr),
        .a_wr_data(a_wr_data), .a_rd_data(a_rd_data),
        .b_req(b_req), .b_ack(b_ack), .b_rd_wr_L(b_rd_wr_L), .b_addr(b_addr),
        .b_wr_data(b_wr_data), .b_rd_data(b_rd_data),
`ifdef UDP_REG_ARB_LOCK_EN
        .a_lock(a_lock), .b_lock(b_lock),
`endif
        .core_reg_req(core_reg_req), .core_reg_ack(core_reg_ack),
        .core_reg_rd_wr_L(core_reg_rd_wr_L), .core_reg_addr(core_reg_addr),
        .core_reg_wr_data(core_reg_wr_data), .core_reg_rd_data(core_reg_rd_data)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Register-master model controls and completion log.
    int            m_lat   = 3;
    bit            m_rand  = 1'b0;
    bit            m_fixed = 1'b1;
    logic [DW-1:0] m_data  = '0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          rd_wr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } txn_t;

    txn_t          mq[$];
    int            ack_log[$];
    int            a_acks = 0;
    int            b_acks = 0;
    logic [DW-1:0] exp_a_rd = '0;
    logic [DW-1:0] exp_b_rd = '0;

    // Master: acks m_lat cycles after req rises, needs req low before the next one.
    initial begin : master_model
        int            cnt;
        bit            need_low;
        int            low_run;
        txn_t          t;
        logic [AW-1:0] cap_addr;
        logic          cap_rw;
        logic [DW-1:0] cap_wd;
        cnt = 0; need_low = 1'b0; low_run = 100;
        cap_addr = '0; cap_rw = 1'b0; cap_wd = '0;
        core_reg_ack = 1'b0;
        core_reg_rd_data = '0;
        forever begin
            @(negedge clk);
            core_reg_ack = 1'b0;
            if (reset) begin
                cnt = 0; need_low = 1'b0; low_run = 100;
            end else if (!core_reg_req) begin
                cnt = 0; need_low = 1'b0; low_run++;
            end else begin
                if (low_run > 0) begin
                    checks++;
                    if (low_run < 2) begin
                        failures++;
                        $display("FAIL req_gap: core_reg_req low for %0d cycles, required >= 2", low_run);
                    end
                    cap_addr = core_reg_addr; cap_rw = core_reg_rd_wr_L; cap_wd = core_reg_wr_data;
                    low_run = 0;
                end else begin
                    checks++;
                    if ({core_reg_addr, core_reg_rd_wr_L, core_reg_wr_data} !== {cap_addr, cap_rw, cap_wd}) begin
                        failures++;
                        $display("FAIL core_stable: addr=%h rw=%b wd=%h, required addr=%h rw=%b wd=%h",
                                 core_reg_addr, core_reg_rd_wr_L, core_reg_wr_data, cap_addr, cap_rw, cap_wd);
                    end
                end
                if (!need_low) begin
                    cnt++;
                    if (cnt >= m_lat) begin
                        core_reg_rd_data = m_fixed ? m_data : DW'($urandom);
                        core_reg_ack = 1'b1;
                        t.addr = core_reg_addr; t.rd_wr = core_reg_rd_wr_L;
                        t.wdata = core_reg_wr_data; t.rdata = core_reg_rd_data;
                        mq.push_back(t);
                        need_low = 1'b1;
                        if (m_rand) m_lat = $urandom_range(1, 6);
                    end
                end
            end
        end
    end

    // Scoreboard: every port ack matches the oldest master completion and that port's request.
    initial begin : ack_monitor
        txn_t t;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                exp_a_rd = '0; exp_b_rd = '0;
            end
            if (a_ack) begin
                a_acks++; ack_log.push_back(0);
                checks++;
                if (mq.size() == 0 || a_req !== 1'b1) begin
                    failures++;
                    $display("FAIL a_ack_orphan: a_ack with a_req=%b pending=%0d, required a_req=1 and a completion", a_req, mq.size());
                end else begin
                    t = mq.pop_front();
                    exp_a_rd = t.rdata;
                    checks++;
                    if ({t.addr, t.rd_wr, t.wdata} !== {a_addr, a_rd_wr_L, a_wr_data}) begin
                        failures++;
                        $display("FAIL a_forward: master saw addr=%h rw=%b wd=%h, required addr=%h rw=%b wd=%h",
                                 t.addr, t.rd_wr, t.wdata, a_addr, a_rd_wr_L, a_wr_data);
                    end
                end
            end
            if (b_ack) begin
                b_acks++; ack_log.push_back(1);
                checks++;
                if (mq.size() == 0 || b_req !== 1'b1) begin
                    failures++;
                    $display("FAIL b_ack_orphan: b_ack with b_req=%b pending=%0d, required b_req=1 and a completion", b_req, mq.size());
                end else begin
                    t = mq.pop_front();
                    exp_b_rd = t.rdata;
                    checks++;
                    if ({t.addr, t.rd_wr, t.wdata} !== {b_addr, b_rd_wr_L, b_wr_data}) begin
                        failures++;
                        $display("FAIL b_forward: master saw addr=%h rw=%b wd=%h, required addr=%h rw=%b wd=%h",
                                 t.addr, t.rd_wr, t.wdata, b_addr, b_rd_wr_L, b_wr_data);
                    end
                end
            end
            checks++;
            if (a_rd_data !== exp_a_rd || b_rd_data !== exp_b_rd) begin
                failures++;
                $display("FAIL rd_data_hold: a=%h b=%h, required a=%h b=%h", a_rd_data, b_rd_data, exp_a_rd, exp_b_rd);
            end
        end
    end

    task automatic wait_port_ack(input bit p, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk); #1;
            ok = p ? b_ack : a_ack;
        end
    endtask

    task automatic drive_port(input bit p, input int n, input int gap_max);
        bit ok;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (p) begin
                b_addr = AW'($urandom); b_rd_wr_L = 1'($urandom); b_wr_data = DW'($urandom); b_req = 1'b1;
            end else begin
                a_addr = AW'($urandom); a_rd_wr_L = 1'($urandom); a_wr_data = DW'($urandom); a_req = 1'b1;
            end
            wait_port_ack(p, 200, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL port%0d_ack_timeout: no ack within 200 cycles, required an ack", p);
            end
            @(negedge clk);
            if (p) b_req = 1'b0; else a_req = 1'b0;
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; a_req = 1'b1; b_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({core_reg_req, core_reg_rd_wr_L, core_reg_addr, core_reg_wr_data, a_ack, b_ack, a_rd_data, b_rd_data} !== '0) begin
                failures++;
                $display("FAIL reset_outputs: req=%b addr=%h a_ack=%b b_ack=%b a_rd=%h b_rd=%h, required all 0",
                         core_reg_req, core_reg_addr, a_ack, b_ack, a_rd_data, b_rd_data);
            end
        end
        @(negedge clk);
        reset = 1'b0; a_req = 1'b0; b_req = 1'b0;
    endtask

    task automatic test_single_read();
        int lat;
        bit ok;
        int b0;
        b0 = b_acks; m_fixed = 1'b1; m_data = 32'h1234_5678; m_lat = 5;
        @(negedge clk);
        a_addr = AW'(12'h040); a_rd_wr_L = 1'b1; a_wr_data = '0; a_req = 1'b1;
        lat = 0; ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(posedge clk); #1;
            lat++;
            ok = a_ack;
        end
        checks++;
        if (!ok || lat != 6) begin
            failures++;
            $display("FAIL read_latency: ack seen=%b after %0d cycles, required ack after 6", ok, lat);
        end
        checks++;
        if (a_rd_data !== 32'h1234_5678) begin
            failures++;
            $display("FAIL read_data: a_rd_data=%h, required 12345678", a_rd_data);
        end
        @(negedge clk); a_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (a_ack !== 1'b0 || a_rd_data !== 32'h1234_5678) begin
            failures++;
            $display("FAIL read_pulse: a_ack=%b a_rd_data=%h, required 0 and 12345678", a_ack, a_rd_data);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (b_acks != b0) begin
            failures++;
            $display("FAIL read_no_b_ack: b acks=%0d, required 0", b_acks - b0);
        end
    endtask

    task automatic test_round_robin();
        pulse_reset();
        ack_log.delete();
        m_fixed = 1'b0; m_lat = 2;
        fork
            drive_port(1'b0, 3, 0);
            drive_port(1'b1, 3, 0);
        join
        checks++;
        if (ack_log.size() != 6) begin
            failures++;
            $display("FAIL rr_count: %0d acks, required 6", ack_log.size());
        end
        for (int i = 0; i < ack_log.size() && i < 6; i++) begin
            checks++;
            if (ack_log[i] != (i % 2)) begin
                failures++;
                $display("FAIL rr_order: transaction %0d went to port %0d, required port %0d", i, ack_log[i], i % 2);
            end
        end
    endtask

    task automatic test_write_hold();
        bit ok;
        int lowcnt;
        m_fixed = 1'b1; m_data = 32'hDEAD_BEEF; m_lat = 4;
        @(negedge clk);
        b_addr = AW'(8'h10); b_rd_wr_L = 1'b0; b_wr_data = 32'hCAFE_F00D; b_req = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(posedge clk); #1;
            if (core_reg_req) begin
                checks++;
                if (core_reg_wr_data !== 32'hCAFE_F00D || core_reg_rd_wr_L !== 1'b0 || core_reg_addr !== AW'(8'h10)) begin
                    failures++;
                    $display("FAIL write_fields: wd=%h rw=%b addr=%h, required CAFEF00D 0 010",
                             core_reg_wr_data, core_reg_rd_wr_L, core_reg_addr);
                end
            end
            ok = b_ack;
        end
        checks++;
        if (!ok || b_rd_data !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL write_ack: ack=%b b_rd_data=%h, required 1 and DEADBEEF", ok, b_rd_data);
        end
        lowcnt = core_reg_req ? 0 : 1;
        @(negedge clk);
        b_req = 1'b0;
        a_addr = AW'(12'h123); a_rd_wr_L = 1'b1; a_wr_data = '0; a_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (core_reg_req) break;
            lowcnt++;
        end
        checks++;
        if (lowcnt < 2 || core_reg_req !== 1'b1 || core_reg_addr !== AW'(12'h123)) begin
            failures++;
            $display("FAIL write_gap: low %0d cycles then req=%b addr=%h, required >=2 then 1 and 123",
                     lowcnt, core_reg_req, core_reg_addr);
        end
        wait_port_ack(1'b0, 30, ok);
        @(negedge clk); a_req = 1'b0;
    endtask

    task automatic test_abort();
        bit ok;
        bit found;
        int a0;
        a0 = a_acks; m_fixed = 1'b0; m_lat = 20;
        @(negedge clk);
        a_addr = AW'(12'h0A0); a_rd_wr_L = 1'b1; a_wr_data = '0; a_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_addr = AW'(12'h0B0); b_rd_wr_L = 1'b1; b_wr_data = '0; b_req = 1'b1;
        @(posedge clk);
        @(negedge clk); a_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (core_reg_req !== 1'b0) begin
            failures++;
            $display("FAIL abort_req: core_reg_req=%b after drop, required 0", core_reg_req);
        end
        m_lat = 3;
        found = 1'b0;
        for (int i = 0; i < 3 && !found; i++) begin
            @(posedge clk); #1;
            found = core_reg_req;
        end
        checks++;
        if (!found || core_reg_addr !== AW'(12'h0B0)) begin
            failures++;
            $display("FAIL abort_regrant: req=%b addr=%h, required 1 and 0b0 within 3 cycles", found, core_reg_addr);
        end
        wait_port_ack(1'b1, 30, ok);
        checks++;
        if (!ok || a_acks != a0) begin
            failures++;
            $display("FAIL abort_acks: b ack=%b extra a acks=%0d, required 1 and 0", ok, a_acks - a0);
        end
        @(negedge clk); b_req = 1'b0;
    endtask

    task automatic test_reset_mid_issue();
        bit ok;
        ack_log.delete();
        m_fixed = 1'b0; m_lat = 50;
        @(negedge clk);
        b_addr = AW'(12'h0B4); b_rd_wr_L = 1'b1; b_wr_data = '0; b_req = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        checks++;
        if (core_reg_req !== 1'b1 || core_reg_addr !== AW'(12'h0B4)) begin
            failures++;
            $display("FAIL rst_issue_pre: req=%b addr=%h, required 1 and 0b4", core_reg_req, core_reg_addr);
        end
        @(negedge clk);
        reset = 1'b1;
        a_addr = AW'(12'h0A4); a_rd_wr_L = 1'b1; a_wr_data = '0; a_req = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({core_reg_req, core_reg_rd_wr_L, core_reg_addr, core_reg_wr_data, a_ack, b_ack, a_rd_data, b_rd_data} !== '0) begin
            failures++;
            $display("FAIL rst_issue_outputs: req=%b addr=%h a_ack=%b b_ack=%b, required all 0",
                     core_reg_req, core_reg_addr, a_ack, b_ack);
        end
        @(negedge clk); reset = 1'b0; m_lat = 3;
        @(posedge clk); #1;
        checks++;
        if (core_reg_req !== 1'b1 || core_reg_addr !== AW'(12'h0A4)) begin
            failures++;
            $display("FAIL rst_issue_regrant: req=%b addr=%h, required 1 and 0a4", core_reg_req, core_reg_addr);
        end
        wait_port_ack(1'b0, 30, ok);
        @(negedge clk); a_req = 1'b0;
        wait_port_ack(1'b1, 30, ok);
        @(negedge clk); b_req = 1'b0;
        checks++;
        if (ack_log.size() != 2 || ack_log[0] != 0 || ack_log[1] != 1) begin
            failures++;
            $display("FAIL rst_issue_order: %0d acks first=%0d, required 2 acks A then B",
                     ack_log.size(), (ack_log.size() > 0) ? ack_log[0] : -1);
        end
    endtask

    task automatic test_random();
        int a0;
        int b0;
        a0 = a_acks; b0 = b_acks;
        m_fixed = 1'b0; m_rand = 1'b1;
        fork
            drive_port(1'b0, 20, 3);
            drive_port(1'b1, 20, 3);
        join
        m_rand = 1'b0; m_lat = 3;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (a_acks - a0 != 20 || b_acks - b0 != 20 || mq.size() != 0) begin
            failures++;
            $display("FAIL random_totals: a=%0d b=%0d leftover=%0d, required 20 20 0",
                     a_acks - a0, b_acks - b0, mq.size());
        end
    endtask

`ifdef UDP_REG_ARB_LOCK_EN
    task automatic test_lock();
        int exp_order[7];
        exp_order = '{0, 0, 0, 0, 1, 0, 0};
        pulse_reset();
        ack_log.delete();
        m_fixed = 1'b0; m_lat = 2; a_lock = 1'b1;
        fork
            drive_port(1'b0, 6, 0);
            drive_port(1'b1, 1, 0);
        join
        a_lock = 1'b0;
        checks++;
        if (ack_log.size() != 7) begin
            failures++;
            $display("FAIL lock_count: %0d acks, required 7", ack_log.size());
        end
        for (int i = 0; i < ack_log.size() && i < 7; i++) begin
            checks++;
            if (ack_log[i] != exp_order[i]) begin
                failures++;
                $display("FAIL lock_order: transaction %0d went to port %0d, required port %0d", i, ack_log[i], exp_order[i]);
            end
        end
    endtask
`endif

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        reset = 1'b1;
        a_req = 1'b0; a_rd_wr_L = 1'b0; a_addr = '0; a_wr_data = '0;
        b_req = 1'b0; b_rd_wr_L = 1'b0; b_addr = '0; b_wr_data = '0;
`ifdef UDP_REG_ARB_LOCK_EN
        a_lock = 1'b0; b_lock = 1'b0;
`endif
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_hold();
        test_abort();
        test_reset_mid_issue();
        test_random();
`ifdef UDP_REG_ARB_LOCK_EN
        test_lock();
`endif
        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
